// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the time-shared AES S-box word engine:
// FSM encoding, beat/counter sizing helpers and configuration legality.
package aes_sbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_LANES = 16;

    function automatic int beats_of(input int lanes, input int nsbox);
        return (nsbox > 0) ? lanes / nsbox : 1;
    endfunction

    // Counter width never collapses to zero bits, even for a single beat.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit cfg_legal(input int lanes, input int nsbox);
        return (lanes >= 1) && (lanes <= MAX_LANES) && (nsbox >= 1) &&
               (nsbox <= lanes) && ((lanes % nsbox) == 0);
    endfunction

endpackage

// File: rtl/bp_aes_sbox.sv
// Single-byte AES S-box, forward or inverse, sharing one GF(2^8) inversion.
// Latency: combinational. Backpressure: none (pure function of x and inv).
// Inverse mode runs the inverse affine map before the shared inversion.
module bp_aes_sbox (
    input  logic [7:0] x,
    input  logic       inv,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] g);
        return g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^
               {g[3:0], g[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] v);
        return {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] pre;
    logic [7:0] g;

    always_comb begin
        pre = inv ? inv_affine(x) : x;
        g   = gf_inv(pre);
        y   = inv ? g : fwd_affine(g);
    end

endmodule

// File: rtl/bp_aes_sbox_word.sv
// LANES-byte SubBytes/InvSubBytes with NSBOX S-boxes time-shared over BEATS=LANES/NSBOX beats.
// Latency: out_valid rises BEATS edges after accept; one word per BEATS+1 cycles sustained.
// Backpressure: result held in DONE until out_ready; in_ready reopens combinationally on handoff.
module bp_aes_sbox_word
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 4,
    parameter int NSBOX = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv
);

    localparam int BEATS = beats_of(LANES, NSBOX);
    localparam int BW    = cnt_width(BEATS);
    localparam int LW    = cnt_width(LANES);

    if (!cfg_legal(LANES, NSBOX)) begin : g_cfg_check
        $error("bp_aes_sbox_word: LANES must be 1..16 and divisible by NSBOX");
    end

    state_t        state;
    logic [BW-1:0] beat;
    logic          inv_q;
    logic [7:0]    lane_q   [LANES];
    logic [7:0]    res_q    [LANES];
    logic [LW-1:0] lane_idx [NSBOX];
    logic [7:0]    sb_out   [NSBOX];
    logic          accept;

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int j = 0; j < NSBOX; j++) begin
            lane_idx[j] = LW'(int'(beat) * NSBOX + j);
        end
    end

    for (genvar j = 0; j < NSBOX; j++) begin : g_sbox
        bp_aes_sbox u_sbox (
            .x   (lane_q[lane_idx[j]]),
            .inv (inv_q),
            .y   (sb_out[j])
        );
    end

    for (genvar i = 0; i < LANES; i++) begin : g_out
        assign out_data[8*i +: 8] = res_q[i];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            beat      <= '0;
            inv_q     <= 1'b0;
            out_valid <= 1'b0;
            out_inv   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= 8'h00;
                res_q[i]  <= 8'h00;
            end
        end else begin
            case (state)
                ST_IDLE: ;
                ST_BUSY: begin
                    for (int j = 0; j < NSBOX; j++) begin
                        res_q[lane_idx[j]] <= sb_out[j];
                    end
                    beat <= beat + 1'b1;
                    if (beat == BW'(BEATS - 1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_inv   <= inv_q;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A new accept (IDLE, or DONE handing off) overrides the state chosen above.
            if (accept) begin
                for (int i = 0; i < LANES; i++) begin
                    lane_q[i] <= in_data[8*i +: 8];
                end
                inv_q <= in_inv;
                beat  <= '0;
                state <= ST_BUSY;
            end
        end
    end

endmodule
